// File: rtl/dac_stream_pkg.sv
// rtl/dac_stream_pkg.sv - FSM state type and midscale helper for the DAC stream interface
package dac_stream_pkg;

    typedef enum logic [1:0] {
        STREAM      = 2'd0,
        CFG_SETUP   = 2'd1,
        CFG_LOW     = 2'd2,
        CFG_RECOVER = 2'd3
    } dac_state_e;

    // Midscale code: MSB set, all other bits clear.
    function automatic logic [31:0] midscale(input int data_w);
        return 32'd1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/dac_sync_fifo.sv
// rtl/dac_sync_fifo.sv - single-clock sample FIFO with extra-bit pointers and registered level
module dac_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Same index with differing wrap bit means the writer is a full lap ahead.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + PTR_ONE;
                2'b01:   level <= level - PTR_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/dac_stream_if.sv
// rtl/dac_stream_if.sv - sample FIFO to parallel DAC bridge with interleaved config write cycles
module dac_stream_if
    import dac_stream_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CFG_HOLD   = 2,
    parameter int SIGNED_IN  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_CH*DATA_W-1:0]           s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_W-1:0]                cfg_data,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    output logic [N_CH*DATA_W-1:0]           dac_d,
    output logic                             dac_cw,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic [15:0]                      underflow_cnt
);

    localparam int W      = N_CH * DATA_W;
    localparam int HOLD_W = (CFG_HOLD > 1) ? $clog2(CFG_HOLD) : 1;
    localparam logic [DATA_W-1:0] MID     = DATA_W'(midscale(DATA_W));
    localparam logic [W-1:0]      MID_ALL = {N_CH{MID}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CFG_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    dac_state_e        state;
    logic [DATA_W-1:0] cfg_word;
    logic [HOLD_W-1:0] hold_cnt;
    logic [W-1:0]      stage_d;
    logic              stage_cw;
    logic [W-1:0]      cfg_frame;
    logic [W-1:0]      fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cfg_hs;
    logic              fifo_wr;
    logic              fifo_rd;

    function automatic logic [W-1:0] convert(input logic [W-1:0] raw);
        logic [W-1:0] res;
        res = raw;
        if (SIGNED_IN != 0) begin
            for (int k = 0; k < N_CH; k++) begin
                res[k*DATA_W + DATA_W - 1] = ~raw[k*DATA_W + DATA_W - 1];
            end
        end
        return res;
    endfunction

    assign s_ready   = !fifo_full && !reset;
    assign cfg_ready = (state == STREAM) && !reset;
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign fifo_wr   = s_valid && s_ready;
    assign fifo_rd   = (state == STREAM) && !cfg_hs && !fifo_empty;

    always_comb begin
        cfg_frame               = MID_ALL;
        cfg_frame[DATA_W-1:0]   = cfg_word;
    end

    dac_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (s_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // stage_* holds the word decided this cycle; dac_* presents it one cycle later,
    // giving the two-edge sample latency and keeping config frames aligned with cw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= STREAM;
            cfg_word      <= '0;
            hold_cnt      <= '0;
            stage_d       <= MID_ALL;
            stage_cw      <= 1'b1;
            dac_d         <= MID_ALL;
            dac_cw        <= 1'b1;
            underflow_cnt <= '0;
        end else begin
            dac_d  <= stage_d;
            dac_cw <= stage_cw;
            case (state)
                STREAM: begin
                    stage_cw <= 1'b1;
                    if (cfg_hs) begin
                        cfg_word <= cfg_data;
                        state    <= CFG_SETUP;
                    end else if (!fifo_empty) begin
                        stage_d <= convert(fifo_rd_data);
                    end else begin
                        stage_d <= MID_ALL;
                        if (underflow_cnt != 16'hFFFF) begin
                            underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end
                end
                CFG_SETUP: begin
                    stage_d  <= cfg_frame;
                    stage_cw <= 1'b1;
                    hold_cnt <= HOLD_LAST;
                    state    <= CFG_LOW;
                end
                CFG_LOW: begin
                    stage_cw <= 1'b0;
                    if (hold_cnt == '0) begin
                        state <= CFG_RECOVER;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                CFG_RECOVER: begin
                    stage_cw <= 1'b1;
                    state    <= STREAM;
                end
                default: begin
                    state <= STREAM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_stream_if.sv
// tb/tb_dac_stream_if.sv - self-checking bench for dac_stream_if against a schedule-based model
module tb_dac_stream_if;

    localparam int N_CH       = 2;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int CFG_HOLD   = 2;
    localparam int SIGNED_IN  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] dac_d;
    logic        dac_cw;
    logic [3:0]  fifo_level;
    logic [15:0] underflow_cnt;

    int checks = 0;
    int errors = 0;

    dac_stream_if #(
        .N_CH       (N_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CFG_HOLD   (CFG_HOLD),
        .SIGNED_IN  (SIGNED_IN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .dac_d         (dac_d),
        .dac_cw        (dac_cw),
        .fifo_level    (fifo_level),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offset-binary conversion as plain per-channel arithmetic.
    function automatic logic [15:0] conv(input logic [15:0] v);
        int lo;
        int hi;
        lo = (int'(v[7:0]) + 128) % 256;
        hi = (int'(v[15:8]) + 128) % 256;
        return (SIGNED_IN != 0) ? {8'(hi), 8'(lo)} : v;
    endfunction

    // Model: a queue for the FIFO, a queue of scheduled config output words, and
    // a one-cycle delay between the word chosen at an edge and what the pins show.
    logic [15:0] q[$];
    logic [16:0] sched[$];
    int          busy = 0;
    int          m_ucnt = 0;
    logic [15:0] m_stage_d = 16'h8080;
    logic        m_stage_cw = 1'b1;
    logic [15:0] m_out_d = 16'h8080;
    logic        m_out_cw = 1'b1;
    int          sz0;
    logic [16:0] plan;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            sched.delete();
            busy       = 0;
            m_ucnt     = 0;
            m_stage_d  = 16'h8080;
            m_stage_cw = 1'b1;
            m_out_d    = 16'h8080;
            m_out_cw   = 1'b1;
        end else begin
            sz0 = q.size();
            if (busy == 0 && cfg_valid) begin
                plan = {1'b1, m_stage_d};
                sched.push_back({1'b1, 8'h80, cfg_data});
                for (int i = 0; i < CFG_HOLD; i++) sched.push_back({1'b0, 8'h80, cfg_data});
                sched.push_back({1'b1, 8'h80, cfg_data});
                busy = CFG_HOLD + 2;
            end else if (busy == 0 && sz0 > 0) begin
                plan = {1'b1, conv(q.pop_front())};
            end else if (busy == 0) begin
                plan = {1'b1, 16'h8080};
                if (m_ucnt < 65535) m_ucnt++;
            end else begin
                plan = sched.pop_front();
                busy--;
            end
            if (s_valid && sz0 < FIFO_DEPTH) q.push_back(s_data);
            m_out_d  = m_stage_d;
            m_out_cw = m_stage_cw;
            {m_stage_cw, m_stage_d} = plan;
        end
    end

    always @(negedge clk) begin
        check("dac_d", dac_d, m_out_d);
        check("dac_cw", dac_cw, m_out_cw);
        check("fifo_level", fifo_level, q.size());
        check("underflow_cnt", underflow_cnt, m_ucnt);
        check("s_ready", s_ready, !reset && q.size() < FIFO_DEPTH);
        check("cfg_ready", cfg_ready, !reset && busy == 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    logic cw_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic found;

    initial begin
        s_valid   = 1'b0;
        s_data    = '0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        reset     = 1'b1;

        // Reset state, then idle underflow counting
        cyc(2);
        check("rst_dac_d", dac_d, 16'h8080);
        check("rst_dac_cw", dac_cw, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b0);
        reset = 1'b0;
        cyc(10);
        check("idle_ucnt10", underflow_cnt, 16'd10);
        check("idle_dac_d", dac_d, 16'h8080);

        // Two-sample stream and its latency
        s_valid = 1'b1;
        s_data  = 16'h7F80;
        cyc(1);
        s_data  = 16'h00FF;
        cyc(1);
        s_valid = 1'b0;
        cyc(1);
        check("stream_k2", dac_d, 16'hFF00);
        cyc(1);
        check("stream_k3", dac_d, 16'h807F);
        cyc(2);

        // Config write with a sample offered on the handshake cycle
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        s_valid   = 1'b1;
        s_data    = 16'h1234;
        cyc(1);
        check("cfg_sample_held", fifo_level, 4'd1);
        check("cfg_ready_busy", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("cfg_frame_d", dac_d, 16'h80A5);
            check("cfg_frame_cw", dac_cw, cw_seq[i]);
        end
        cyc(1);
        check("cfg_resume_d", dac_d, 16'h92B4);
        check("cfg_resume_lvl", fifo_level, 4'd0);

        // Fill while config repeatedly blocks the read side
        cfg_data  = 8'h3C;
        cfg_valid = 1'b1;
        s_valid   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            s_data = {8'(i), 8'(i + 64)};
            cyc(1);
            if (i == 8) begin
                check("fill_level8", fifo_level, 4'd8);
                check("fill_s_ready0", s_ready, 1'b0);
            end
        end
        check("fill_no_9th", fifo_level, 4'd8);
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            cyc(1);
            if (dac_d == 16'h81C1) found = 1'b1;
        end
        check("drain_first_seen", found, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            cyc(1);
            check("drain_order", dac_d, {8'(8'h80 + i), 8'(8'hC0 + i)});
        end
        cyc(3);

        // Reset pulse while dac_cw is low
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        s_valid   = 1'b1;
        s_data    = 16'h4444;
        cyc(1);
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        cyc(3);
        check("midcfg_cw_low", dac_cw, 1'b0);
        check("midcfg_level1", fifo_level, 4'd1);
        reset = 1'b1;
        #1;
        check("async_rst_cw", dac_cw, 1'b1);
        check("async_rst_level", fifo_level, 4'd0);
        check("async_rst_dac_d", dac_d, 16'h8080);
        check("async_rst_cfg_ready", cfg_ready, 1'b0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("post_rst_stream", cfg_ready, 1'b1);
        check("post_rst_ucnt", underflow_cnt, 16'd1);

        // Underflow counter saturation
        cyc(70000);
        check("ucnt_saturated", underflow_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
